chacha_mem_arbiter: RTL and testbench

CHACHA_MEM_ARBITER -- requirements
Module: chacha_mem_arbiter

---
 rtl/chacha_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_chacha_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_mem_arbiter.sv
// Two-master arbiter sharing one single-port data RAM between the CPU (m0) and
// the ChaCha20 core (m1), with bounded m1 block locking and per-port stall counters.
module chacha_mem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                stall_clr,
  output logic [15:0]         m0_stall_cnt,
  output logic [15:0]         m1_stall_cnt
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic              req0, req1, gnt0, gnt1, lock, gnt_rd;
  logic              last_gnt;
  logic              m1_gnt_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic              rd_pend, rd_owner;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign lock = m1_lock & m1_gnt_q & (hold_cnt < HOLD_W'(MAX_HOLD));

  // Once hold_cnt reaches MAX_HOLD the lock drops and round-robin hands m0 one slot.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 & req1) begin
      if (lock | ~last_gnt) gnt1 = 1'b1;
      else                  gnt0 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (gnt0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
    end else if (gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
  end

  assign gnt_rd           = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
  assign mem_chipselect   = gnt0 | gnt1;
  assign mem_clken        = 1'b1;
  assign m0_waitrequest   = req0 & ~gnt0;
  assign m1_waitrequest   = req1 & ~gnt1;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend & ~rd_owner;
  assign m1_readdatavalid = rd_pend & rd_owner;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= 1'b1;
      m1_gnt_q <= 1'b0;
      hold_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      if (gnt0 | gnt1) last_gnt <= gnt1;
      m1_gnt_q <= gnt1;
      if (gnt0 | ~m1_lock)
        hold_cnt <= '0;
      else if (lock & gnt1 & req0)
        hold_cnt <= hold_cnt + HOLD_W'(1);
      rd_pend  <= gnt_rd;
      rd_owner <= gnt1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_stall_cnt <= '0;
      m1_stall_cnt <= '0;
    end else if (stall_clr) begin
      m0_stall_cnt <= '0;
      m1_stall_cnt <= '0;
    end else begin
      if (m0_waitrequest && m0_stall_cnt != 16'hFFFF) m0_stall_cnt <= m0_stall_cnt + 16'd1;
      if (m1_waitrequest && m1_stall_cnt != 16'hFFFF) m1_stall_cnt <= m1_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_chacha_mem_arbiter.sv
// Self-checking bench for chacha_mem_arbiter: reference arbitration model, RAM model
// and a read-return scoreboard queue checked against every DUT cycle.
module tb_chacha_mem_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 32;
  localparam int MAX_HOLD = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic [3:0]        m0_byteenable = '0, m1_byteenable = '0;
  logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0]       m0_writedata = '0, m1_writedata = '0;
  logic              m1_lock = 1'b0, stall_clr = 1'b0;
  logic              m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0]       m0_readdata, m1_readdata, mem_writedata, mem_readdata;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [15:0]       m0_stall_cnt, m1_stall_cnt;

  chacha_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .stall_clr(stall_clr), .m0_stall_cnt(m0_stall_cnt), .m1_stall_cnt(m1_stall_cnt)
  );

  always #5 clk = ~clk;

  // Single-port RAM with byte lanes and one cycle of read latency
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  logic [31:0] ram_q = '0;
  logic [31:0] be_mask;
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < 4; b++) be_mask[8*b +: 8] = {8{mem_byteenable[b]}};
  end
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) ram[mem_address] <= (ram[mem_address] & ~be_mask) | (mem_writedata & be_mask);
      else           ram_q <= ram[mem_address];
    end
  end
  assign mem_readdata = ram_q;

  typedef struct {logic port; logic [31:0] data;} rd_t;
  rd_t sb[$];

  int n_checks = 0;
  int n_fail = 0;
  int exp_hold;
  logic exp_last, exp_prev1;
  logic [15:0] exp_stall0, exp_stall1;
  logic obs_g0, obs_g1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_m0(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    m0_read = r; m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic drive_m1(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    m1_read = r; m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic go_idle();
    drive_m0(0, 0, '0, '0, '0);
    drive_m1(0, 0, '0, '0, '0);
  endtask

  // One bus cycle: predict grant, check comb and registered outputs, update the model
  task automatic applyStimulus();
    logic r0, r1, g0, g1, lk;
    rd_t e;
    @(negedge clk);
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    lk = m1_lock && exp_prev1 && (exp_hold < MAX_HOLD);
    if (r0 && r1) begin
      g1 = lk || (exp_last == 1'b0);
      g0 = !g1;
    end else begin
      g0 = r0;
      g1 = r1;
    end
    obs_g0 = r0 && !m0_waitrequest;
    obs_g1 = r1 && !m1_waitrequest;
    checkOutput("m0_wait", m0_waitrequest, r0 && !g0);
    checkOutput("m1_wait", m1_waitrequest, r1 && !g1);
    checkOutput("chipsel", mem_chipselect, g0 || g1);
    checkOutput("clken", mem_clken, 1'b1);
    if (g0) begin
      checkOutput("addr0", mem_address, m0_address);
      checkOutput("be0", mem_byteenable, m0_byteenable);
      checkOutput("wr0", mem_write, m0_write);
      if (m0_write) checkOutput("wdata0", mem_writedata, m0_writedata);
    end else if (g1) begin
      checkOutput("addr1", mem_address, m1_address);
      checkOutput("be1", mem_byteenable, m1_byteenable);
      checkOutput("wr1", mem_write, m1_write);
      if (m1_write) checkOutput("wdata1", mem_writedata, m1_writedata);
    end else begin
      checkOutput("addr_idle", mem_address, '0);
      checkOutput("wr_idle", mem_write, 1'b0);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("rdv0", m0_readdatavalid, e.port == 1'b0);
      checkOutput("rdv1", m1_readdatavalid, e.port == 1'b1);
      if (e.port) checkOutput("rdata1", m1_readdata, e.data);
      else        checkOutput("rdata0", m0_readdata, e.data);
    end else begin
      checkOutput("rdv0_idle", m0_readdatavalid, 1'b0);
      checkOutput("rdv1_idle", m1_readdatavalid, 1'b0);
    end
    checkOutput("stall0", m0_stall_cnt, exp_stall0);
    checkOutput("stall1", m1_stall_cnt, exp_stall1);
    if (g0 && m0_read && !m0_write) sb.push_back('{1'b0, ram[m0_address]});
    if (g1 && m1_read && !m1_write) sb.push_back('{1'b1, ram[m1_address]});
    if (stall_clr) begin
      exp_stall0 = '0;
      exp_stall1 = '0;
    end else begin
      if (r0 && !g0 && exp_stall0 != 16'hFFFF) exp_stall0 = exp_stall0 + 16'd1;
      if (r1 && !g1 && exp_stall1 != 16'hFFFF) exp_stall1 = exp_stall1 + 16'd1;
    end
    if (g0 || !m1_lock) exp_hold = 0;
    else if (lk && g1 && r0) exp_hold++;
    if (g0 || g1) exp_last = g1;
    exp_prev1 = g1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    checkOutput("rst_rdv0", m0_readdatavalid, 1'b0);
    checkOutput("rst_rdv1", m1_readdatavalid, 1'b0);
    checkOutput("rst_stall0", m0_stall_cnt, 16'd0);
    checkOutput("rst_stall1", m1_stall_cnt, 16'd0);
    sb.delete();
    exp_hold = 0; exp_last = 1'b1; exp_prev1 = 1'b0;
    exp_stall0 = '0; exp_stall1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'h5A00_0000 | i;
    go_idle();
    do_reset();
    applyStimulus();

    // Write then read back on m0
    drive_m0(0, 1, 14'h0010, 4'hF, 32'hDEADBEEF);
    applyStimulus();
    drive_m0(1, 0, 14'h0010, 4'hF, '0);
    applyStimulus();
    go_idle();
    checkOutput("wr_rd_rdv0", m0_readdatavalid, 1'b1);
    checkOutput("wr_rd_data", m0_readdata, 32'hDEADBEEF);
    checkOutput("wr_rd_rdv1", m1_readdatavalid, 1'b0);
    applyStimulus();

    // Read and write together: the write wins and no data returns
    drive_m0(1, 1, 14'h0011, 4'hF, 32'h0BAD_F00D);
    applyStimulus();
    go_idle();
    checkOutput("rw_no_rdv", m0_readdatavalid, 1'b0);
    applyStimulus();

    // Partial byte write over a full word
    drive_m0(0, 1, 14'h0020, 4'hF, 32'hAAAAAAAA);
    applyStimulus();
    drive_m0(0, 1, 14'h0020, 4'h3, 32'h11223344);
    applyStimulus();
    drive_m0(1, 0, 14'h0020, 4'hF, '0);
    applyStimulus();
    go_idle();
    checkOutput("be_merge", m0_readdata, 32'hAAAA3344);
    applyStimulus();

    // Both masters reading continuously from reset alternate m0 first
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive_m0(1, 0, 14'h0040 + 14'(k), 4'hF, '0);
      drive_m1(1, 0, 14'h0080 + 14'(k), 4'hF, '0);
      applyStimulus();
      checkOutput("alt_g0", obs_g0, (k % 2) == 0);
    end
    go_idle();
    checkOutput("alt_stall0", m0_stall_cnt, 16'd5);
    checkOutput("alt_stall1", m1_stall_cnt, 16'd5);
    applyStimulus();

    // Locked m1 traffic: one m0 slot after each run of locked grants
    do_reset();
    m1_lock = 1'b1;
    for (int k = 0; k < 40; k++) begin
      drive_m0(1, 0, 14'h0100 + 14'(k), 4'hF, '0);
      drive_m1(1, 0, 14'h0200 + 14'(k), 4'hF, '0);
      applyStimulus();
      checkOutput("lock_pat", obs_g1, (k % (MAX_HOLD + 2)) != 0);
    end
    go_idle();
    m1_lock = 1'b0;
    applyStimulus();

    // Reset arriving while an m1 read is in flight
    drive_m1(1, 0, 14'h0033, 4'hF, '0);
    applyStimulus();
    go_idle();
    do_reset();
    applyStimulus();
    drive_m0(1, 0, 14'h0034, 4'hF, '0);
    drive_m1(1, 0, 14'h0035, 4'hF, '0);
    applyStimulus();
    checkOutput("post_rst_tie", obs_g0, 1'b1);

    // Long contention saturates the m0 stall counter, then clear
    m1_lock = 1'b1;
    drive_m0(1, 0, 14'h0300, 4'hF, '0);
    drive_m1(0, 1, 14'h0301, 4'hF, 32'h1234_5678);
    for (int k = 0; k < 70000; k++) applyStimulus();
    go_idle();
    m1_lock = 1'b0;
    checkOutput("sat_stall0", m0_stall_cnt, 16'hFFFF);
    stall_clr = 1'b1;
    applyStimulus();
    stall_clr = 1'b0;
    checkOutput("clr_stall0", m0_stall_cnt, 16'h0000);
    checkOutput("clr_stall1", m1_stall_cnt, 16'h0000);
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
